// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit geometry, PE credit budget and the flit field
// layout used by the router, plus the FIFO operation encoding.
package noc_pkg;

    localparam int FLIT_W     = 20;
    localparam int PE_CREDITS = 4;
    localparam int PE_CNT_W   = $clog2(PE_CREDITS + 1);

    // Flit field layout, MSB first: dest | src | payload
    localparam int DEST_W      = 4;
    localparam int SRC_W       = 4;
    localparam int PAYLOAD_W   = 12;
    localparam int PAYLOAD_LSB = 0;
    localparam int SRC_LSB     = PAYLOAD_LSB + PAYLOAD_W;
    localparam int DEST_LSB    = SRC_LSB + SRC_W;

    typedef struct packed {
        logic [DEST_W-1:0]    dest;
        logic [SRC_W-1:0]     src;
        logic [PAYLOAD_W-1:0] payload;
    } flit_t;

    // What the FIFO does this cycle, encoded as {push, pop}
    typedef enum logic [1:0] {
        FIFO_IDLE = 2'b00,
        FIFO_POP  = 2'b01,
        FIFO_PUSH = 2'b10,
        FIFO_BOTH = 2'b11
    } fifo_op_e;

endpackage

// File: rtl/noc_flit_fifo.sv
// First-word-fall-through flit FIFO: storage, wrap-around pointers and the
// occupancy counter. DEPTH need not be a power of two, so pointers wrap by
// compare-and-clear instead of natural overflow.
import noc_pkg::*;

module noc_flit_fifo #(
    parameter int FLIT_W = noc_pkg::FLIT_W,
    parameter int DEPTH  = noc_pkg::PE_CREDITS,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              RST,
    input  logic              push,
    input  logic              pop,
    input  logic [FLIT_W-1:0] wr_data,
    output logic [FLIT_W-1:0] rd_data,
    output logic [CNT_W-1:0]  occupancy
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [FLIT_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0] occ_reg, occ_next;
    fifo_op_e         op;

    assign op = fifo_op_e'({push, pop});

    // Next-state for pointers and occupancy; simultaneous push/pop leaves the count alone
    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        occ_next    = occ_reg;
        if (push) begin
            wr_ptr_next = (wr_ptr_reg == LAST_PTR) ? '0 : wr_ptr_reg + 1'b1;
        end
        if (pop) begin
            rd_ptr_next = (rd_ptr_reg == LAST_PTR) ? '0 : rd_ptr_reg + 1'b1;
        end
        case (op)
            FIFO_PUSH: occ_next = occ_reg + 1'b1;
            FIFO_POP:  occ_next = occ_reg - 1'b1;
            default:   occ_next = occ_reg;
        endcase
    end

    // Pointer and occupancy registers; reset discards whatever is held
    always_ff @(posedge clk) begin
        if (RST) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            occ_reg    <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            occ_reg    <= occ_next;
        end
    end

    // Per-entry storage write; contents are deliberately left alone on reset
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk) begin
            if (push && (wr_ptr_reg == PTR_W'(gi))) begin
                mem[gi] <= wr_data;
            end
        end
    end

    assign rd_data   = mem[rd_ptr_reg];
    assign occupancy = occ_reg;

endmodule

// File: rtl/noc_credit_rx_port.sv
// Receive side of the credit-based PE<->router link. Buffers incoming flits
// in a FWFT FIFO, returns one registered credit pulse per flit consumed and
// flags (stickily) any flit that arrives with no room left.
import noc_pkg::*;

module noc_credit_rx_port #(
    parameter int FLIT_W = noc_pkg::FLIT_W,
    parameter int DEPTH  = noc_pkg::PE_CREDITS,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              RST,
    input  logic [FLIT_W-1:0] datain,
    input  logic              in_valid,
    output logic              co,
    output logic [FLIT_W-1:0] dataout,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  occupancy,
    output logic              ovf_err
);

    logic push;
    logic pop;
    logic full;
    logic co_reg;
    logic ovf_reg;

    assign full      = (occupancy == CNT_W'(DEPTH));
    assign out_valid = (occupancy != '0);
    assign pop       = out_valid & out_ready;
    // A full buffer still accepts a flit when the head leaves in the same cycle
    assign push      = in_valid & (~full | pop);

    noc_flit_fifo #(
        .FLIT_W (FLIT_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .RST       (RST),
        .push      (push),
        .pop       (pop),
        .wr_data   (datain),
        .rd_data   (dataout),
        .occupancy (occupancy)
    );

    // Credit return one cycle after each pop; sticky overflow on a dropped flit
    always_ff @(posedge clk) begin
        if (RST) begin
            co_reg  <= 1'b0;
            ovf_reg <= 1'b0;
        end else begin
            co_reg  <= pop;
            ovf_reg <= ovf_reg | (in_valid & full & ~pop);
        end
    end

    assign co      = co_reg;
    assign ovf_err = ovf_reg;

endmodule
